// File: rtl/mul_operand_sequencer.sv
// Operand sequencer in front of the repeated-addition multiplier.
// Feeds A then B on the shared bus, buffers the product, flags timeouts.
module mul_operand_sequencer #(
  parameter int W       = 16,
  parameter int TIMEOUT = 1024,
  parameter int CW      = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         mul_start,
  output logic [W-1:0] mul_data,
  input  logic         mul_ld_a,
  input  logic         mul_ld_b,
  input  logic         mul_done,
  input  logic [W-1:0] mul_product,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_product,
  output logic         busy,
  output logic         err_timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_RUN
  } state_t;

  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          done_q;
  logic          start_q, start_d;
  logic [W-1:0]  data_q, data_d;
  logic          rdy_q, rdy_d;
  logic          busy_q, busy_d;
  logic          ov_q, ov_d;
  logic [W-1:0]  prod_q, prod_d;
  logic          err_q, err_d;

  logic          done_rise;
  logic          buf_free;
  logic [CW-1:0] cnt_inc;
  logic          at_limit;
  logic          cap;
  logic          tmo;

  assign done_rise = mul_done & ~done_q;
  assign buf_free  = ~ov_q | out_ready;
  assign cnt_inc   = (cnt_q == TMO) ? cnt_q : cnt_q + 1'b1;
  assign at_limit  = (cnt_inc == TMO);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
      data_q  <= '0;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      ov_q    <= 1'b0;
      prod_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      done_q  <= mul_done;
      start_q <= start_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      ov_q    <= ov_d;
      prod_q  <= prod_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    cap     = 1'b0;
    tmo     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          cnt_d   = '0;
          state_d = S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        cnt_d = cnt_inc;
        if (at_limit)      tmo     = 1'b1;
        else if (mul_ld_a) state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        cnt_d = cnt_inc;
        if (at_limit)      tmo     = 1'b1;
        else if (mul_ld_b) state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = cnt_inc;
        // A seen completion is never overridden by the timeout.
        if (done_rise || pend_q) begin
          if (buf_free) begin
            cap     = 1'b1;
            pend_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            pend_d  = 1'b1;
          end
        end else if (at_limit) begin
          tmo = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (tmo) state_d = S_IDLE;
  end

  always_comb begin
    start_d = (state_d == S_LOAD_A);
    rdy_d   = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    data_d  = '0;
    unique case (state_d)
      S_LOAD_A: data_d = a_d;
      S_LOAD_B: data_d = b_d;
      default:  data_d = '0;
    endcase
    ov_d   = cap | (ov_q & ~out_ready);
    prod_d = cap ? mul_product : prod_q;
    err_d  = err_q | tmo;
  end

  assign in_ready    = rdy_q;
  assign mul_start   = start_q;
  assign mul_data    = data_q;
  assign out_valid   = ov_q;
  assign out_product = prod_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_mul_operand_sequencer.sv
// Bench for mul_operand_sequencer: behavioural multiplier controller
// model plus a product scoreboard drained by an independent monitor.
module tb_mul_operand_sequencer;
  localparam int W       = 16;
  localparam int TIMEOUT = 1024;
  localparam int CW      = 11;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         mul_start;
  logic [W-1:0] mul_data;
  logic         mul_ld_a;
  logic         mul_ld_b;
  logic         mul_done;
  logic [W-1:0] mul_product;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_product;
  logic         busy;
  logic         err_timeout;

  mul_operand_sequencer #(
    .W(W), .TIMEOUT(TIMEOUT), .CW(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .mul_start(mul_start),
    .mul_data(mul_data),
    .mul_ld_a(mul_ld_a),
    .mul_ld_b(mul_ld_b),
    .mul_done(mul_done),
    .mul_product(mul_product),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_product(out_product),
    .busy(busy),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] sb_q[$];
  logic [W-1:0] cur_a = '0;
  logic [W-1:0] cur_b = '0;
  int           done_hold = 0;
  bit           hang = 1'b0;
  bit           ctl_busy = 1'b0;
  bit           rand_ready = 1'b0;
  logic [W-1:0] ctl_la;
  logic [W-1:0] ctl_lb;
  bit           hold_prev = 1'b0;
  logic [W-1:0] hold_val;
  logic [W-1:0] sb_exp;
  int           stale_bad;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push, input int hold);
    int n = 0;
    while (!in_ready && n < 2000) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      fail_bound("issue_wait");
      return;
    end
    done_hold = hold;
    cur_a     = a;
    cur_b     = b;
    in_a      = a;
    in_b      = b;
    in_valid  = 1'b1;
    if (push) sb_q.push_back(W'(a * b));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done_rise();
    int n = 0;
    while (mul_done && n < 200) begin
      tick();
      n++;
    end
    while (!mul_done && n < 400) begin
      tick();
      n++;
    end
    if (!mul_done) fail_bound("done_rise");
  endtask

  // Controller + datapath model: ldA, then ldB, then b additions, then done.
  initial begin
    mul_ld_a    = 1'b0;
    mul_ld_b    = 1'b0;
    mul_done    = 1'b0;
    mul_product = '0;
    forever begin
      @(negedge clk);
      if (rst_n && mul_start) begin
        ctl_busy = 1'b1;
        @(negedge clk);
        mul_ld_a = 1'b1;
        ctl_la   = mul_data;
        chk("ldA_data", int'(mul_data), int'(cur_a));
        chk("ldA_start", int'(mul_start), 1);
        @(negedge clk);
        mul_ld_a = 1'b0;
        mul_ld_b = 1'b1;
        ctl_lb   = mul_data;
        chk("ldB_data", int'(mul_data), int'(cur_b));
        chk("ldB_start", int'(mul_start), 0);
        @(negedge clk);
        mul_ld_b = 1'b0;
        repeat (done_hold) @(negedge clk);
        mul_done = 1'b0;
        repeat (int'(ctl_lb > 16'd64 ? 16'd64 : ctl_lb)) @(negedge clk);
        @(negedge clk);
        if (!hang) begin
          mul_product = ctl_la * ctl_lb;
          mul_done    = 1'b1;
        end
        ctl_busy = 1'b0;
      end
    end
  end

  // Monitor: pops an expected product on every accepted result.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) begin
          chk("hold_valid", int'(out_valid), 1);
          chk("hold_product", int'(out_product), int'(hold_val));
        end
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got %0d expected nothing",
                     out_product);
          end else begin
            sb_exp = sb_q.pop_front();
            chk("sb_product", int'(out_product), int'(sb_exp));
          end
        end
        hold_prev = out_valid && !out_ready;
        hold_val  = out_product;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom % 2) == 0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_start", int'(mul_start), 0);
    chk("rst_data", int'(mul_data), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_product", int'(out_product), 0);
    chk("rst_err", int'(err_timeout), 0);
    rst_n = 1'b1;
    tick();

    // 17 x 5
    issue(16'd17, 16'd5, 1'b1, 0);
    wait_done_rise();
    chk("t1_pre_capture", int'(out_valid), 0);
    tick();
    chk("t1_valid", int'(out_valid), 1);
    chk("t1_product", int'(out_product), 85);
    chk("t1_start", int'(mul_start), 0);
    chk("t1_busy", int'(busy), 0);

    // backpressure: accept 3 x 4 while 85 is still buffered
    chk("t2_accept_ready", int'(in_ready), 1);
    issue(16'd3, 16'd4, 1'b1, 0);
    wait_done_rise();
    repeat (3) tick();
    chk("t2_stall_busy", int'(busy), 1);
    chk("t2_stall_valid", int'(out_valid), 1);
    chk("t2_stall_product", int'(out_product), 85);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t2_swap_valid", int'(out_valid), 1);
    chk("t2_swap_product", int'(out_product), 12);
    chk("t2_swap_busy", int'(busy), 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // multiplier of zero
    issue(16'd9, 16'd0, 1'b1, 0);
    wait_done_rise();
    tick();
    chk("t3_valid", int'(out_valid), 1);
    chk("t3_product", int'(out_product), 0);
    chk("t3_err", int'(err_timeout), 0);

    // done never arrives
    hang = 1'b1;
    issue(16'd21, 16'd3, 1'b0, 0);
    chk("t4_start", int'(mul_start), 1);
    repeat (TIMEOUT - 1) tick();
    chk("t4_err_before", int'(err_timeout), 0);
    chk("t4_busy_before", int'(busy), 1);
    tick();
    chk("t4_err", int'(err_timeout), 1);
    chk("t4_in_ready", int'(in_ready), 1);
    chk("t4_busy", int'(busy), 0);
    chk("t4_start_off", int'(mul_start), 0);
    chk("t4_out_valid", int'(out_valid), 1);
    chk("t4_out_product", int'(out_product), 0);
    hang = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t4_err_sticky", int'(err_timeout), 1);

    // stale done level carried into a new request
    issue(16'd6, 16'd7, 1'b1, 0);
    wait_done_rise();
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    issue(16'd9, 16'd2, 1'b1, 4);
    stale_bad = 0;
    repeat (8) begin
      if (out_valid) stale_bad++;
      tick();
    end
    chk("t5_stale_no_capture", stale_bad, 0);
    chk("t5_busy", int'(busy), 1);
    wait_done_rise();
    tick();
    chk("t5_valid", int'(out_valid), 1);
    chk("t5_product", int'(out_product), 18);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // reset in the middle of RUN
    chk("t6_err_pre", int'(err_timeout), 1);
    issue(16'd17, 16'd5, 1'b1, 0);
    repeat (4) tick();
    chk("t6_busy_run", int'(busy), 1);
    rst_n = 1'b0;
    sb_q.delete();
    tick();
    chk("t6_start", int'(mul_start), 0);
    chk("t6_data", int'(mul_data), 0);
    chk("t6_out_valid", int'(out_valid), 0);
    chk("t6_out_product", int'(out_product), 0);
    chk("t6_err", int'(err_timeout), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;
    for (int n = 0; n < 200 && ctl_busy; n++) tick();
    if (ctl_busy) fail_bound("t6_ctl_idle");
    tick();
    issue(16'd17, 16'd5, 1'b1, 0);
    wait_done_rise();
    tick();
    chk("t6_valid", int'(out_valid), 1);
    chk("t6_product", int'(out_product), 85);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // random traffic with random consumer backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      issue(W'($urandom), W'($urandom_range(0, 15)), 1'b1,
            int'($urandom_range(0, 2)));
      repeat ($urandom_range(0, 3)) tick();
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    for (int n = 0; n < 3000 && (sb_q.size() != 0 || busy); n++) tick();
    chk("drain_empty", sb_q.size(), 0);
    chk("final_err", int'(err_timeout), 0);
    tick();
    out_ready = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_operand_sequencer.md
Name: mul_operand_sequencer

Overview:
- Front-end stage sitting directly upstream of the repeated-addition multiplier (controller + data_path pair).
- Accepts an operand pair over a valid/ready handshake and drives the multiplier's shared data_in bus and start line, timed by the controller's ldA/ldB strobes.
- Detects done, captures the product into a one-deep output buffer, and returns it over a valid/ready handshake.
- Flags a sticky timeout if the multiplier never completes.

Parameters:
- W, 16, operand, bus and product width (matches multiplier data_in).
- TIMEOUT, 1024, maximum cycles from LOAD_A entry to done before abort.
- CW, 11, width of the timeout counter; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  sequencer can accept an operand pair.
- in_a  input  W  multiplicand.
- in_b  input  W  multiplier (repeat count).
- mul_start  output  1  to controller start.
- mul_data  output  W  to data_path data_in.
- mul_ld_a  input  1  controller ldA strobe.
- mul_ld_b  input  1  controller ldB strobe.
- mul_done  input  1  controller done.
- mul_product  input  W  data_path product register.
- out_valid  output  1  product buffer holds a result.
- out_ready  input  1  consumer accepts the result.
- out_product  output  W  buffered product.
- busy  output  1  high in every state except IDLE.
- err_timeout  output  1  sticky abort flag.

Behaviour:
- Reset (rst_n=0 at a clk edge) forces the following values; it takes priority over all other events, including mid-operation:
  - state = IDLE;
  - mul_start, out_valid, err_timeout, busy = 0;
  - mul_data, out_product = 0;
  - counter = 0, done_d = 0.
- FSM states: IDLE, LOAD_A, LOAD_B, RUN. All outputs are registered.
- IDLE:
  - in_ready = 1.
  - When in_valid is high, latch a_reg = in_a and b_reg = in_b, clear the counter and go to LOAD_A.
  - in_ready = 0 in all other states.
- LOAD_A:
  - mul_start = 1, mul_data = a_reg.
  - On mul_ld_a = 1, go to LOAD_B.
  - mul_start drops on the same edge.
- LOAD_B:
  - mul_start = 0, mul_data = b_reg.
  - On mul_ld_b = 1, go to RUN.
- RUN:
  - mul_data = 0.
  - Wait for a rising edge of mul_done (mul_done & ~done_d, with done_d registered every cycle).
  - A done level that is already high on LOAD_A entry is never treated as completion.
- Completion, on a done edge in RUN:
  - If out_valid = 0, or out_ready = 1 in the same cycle, load out_product = mul_product, set out_valid = 1 and go to IDLE.
  - Otherwise stay in RUN with a pending flag set, and capture on the first cycle in which the buffer frees.
  - The multiplier holds its product until it is restarted, so the pending capture reads a stable value.
- Output handshake:
  - out_valid clears when out_ready = 1 and no new capture occurs that cycle.
  - Simultaneous release and capture leaves out_valid = 1 with the new product.
  - out_product is stable while out_valid = 1 and out_ready = 0.
- Back-to-back operation: a new pair may be accepted while a previous result is still unconsumed in the buffer.
- Timeout:
  - The counter increments every cycle in LOAD_A, LOAD_B and RUN, saturating at TIMEOUT.
  - On reaching TIMEOUT: set err_timeout = 1, force mul_start = 0, return to IDLE and capture no product.
  - err_timeout is cleared only by reset.
  - A done edge and timeout in the same cycle: done wins and no error is raised.
- Strobe ordering: a mul_ld_b seen in LOAD_A, or a mul_ld_a seen in LOAD_B, is ignored.
- Arithmetic: no arithmetic on data. The product is passed through at width W; overflow wrap is the multiplier's concern.

Test Plan:
- Operands 17, 5, with a controller model pulsing ldA 1 cycle and ldB 2 cycles after start, then done after 5 additions:
  - mul_data = 17 during ldA and 5 during ldB;
  - mul_start high only in LOAD_A;
  - out_valid = 1 with out_product = 85 one cycle after the done edge.
- Result backpressure:
  - Result held with out_ready = 0 while a second pair (3, 4) is accepted.
  - The done edge for that pair is stalled in RUN until out_ready = 1.
  - Then 85 drains and 12 loads on the same edge.
- Multiplier (in_b) = 0, done asserted immediately after ldB: out_product = 0 and no timeout.
- Multiplier never raises done:
  - err_timeout = 1 exactly TIMEOUT cycles after LOAD_A entry;
  - state returns to IDLE, in_ready = 1, out_valid unchanged.
- Stale done level:
  - mul_done held high from a previous run into a new request;
  - no capture occurs until done falls and rises again.
- Reset mid-RUN, with rst_n = 0 for 1 cycle:
  - all outputs return to their reset values on the next edge;
  - err_timeout cleared;
  - a subsequent 17 × 5 run yields 85.
